product_accumulator: RTL and testbench



---
 rtl/product_accumulator.sv | 80 ++++++++
 tb/tb_product_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: accumulates framed multiplier products into a sum with saturating count and sticky overflow
module product_accumulator #(
  parameter int PW = 8,
  parameter int AW = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t        state_q;
  logic [AW-1:0] acc_q, sum_q;
  logic [CW-1:0] cnt_q, count_q;
  logic          ovf_q, out_ovf_q, out_valid_q, in_ready_q;
  logic [AW:0]   add_d;
  logic [CW-1:0] cnt_d;
  logic          ovf_d;
  always_comb begin
    add_d = {1'b0, acc_q} + (AW+1)'(in_prod);
    cnt_d = &cnt_q ? cnt_q : cnt_q + CW'(1);
    ovf_d = ovf_q | add_d[AW];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      count_q     <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: if (in_valid && in_ready_q) begin
          if (in_last) begin
            sum_q       <= add_d[AW-1:0];
            count_q     <= cnt_d;
            out_ovf_q   <= ovf_d;
            out_valid_q <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            state_q     <= HOLD;
          end else begin
            acc_q   <= add_d[AW-1:0];
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= ACCUM;
          end
        end
        HOLD: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench driving a default-width and a 9-bit accumulator in lockstep
module tb_product_accumulator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_prod = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [3:0]  out_count;
  logic       in_ready9, out_valid9, out_ovf9;
  logic [8:0] out_sum9;
  logic [3:0] out_count9;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [15:0] s16;
    logic [8:0]  s9;
    logic [3:0]  c;
    logic        o16;
    logic        o9;
  } exp_t;
  exp_t sb[$];
  exp_t e, act;
  int   m16, m9, mc;
  bit   mo16, mo9;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  product_accumulator #(.AW(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid9), .out_ready(out_ready), .out_sum(out_sum9),
    .out_count(out_count9), .out_ovf(out_ovf9)
  );

  task automatic model_clear();
    m16 = 0; m9 = 0; mc = 0; mo16 = 0; mo9 = 0;
  endtask

  task automatic put(input logic [7:0] p, input bit last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_prod = p; in_last = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL put_timeout in_ready stuck at %b, required 1", in_ready);
    end
    if (m16 + p > 65535) mo16 = 1;
    if (m9 + p > 511) mo9 = 1;
    m16 = (m16 + p) % 65536;
    m9  = (m9 + p) % 512;
    mc  = mc < 15 ? mc + 1 : 15;
    if (last) begin
      sb.push_back('{s16: 16'(m16), s9: 9'(m9), c: 4'(mc), o16: mo16, o9: mo9});
      model_clear();
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_sum, out_count, out_ovf} !== {1'b0, 1'b1, 16'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b s=%0d c=%0d o=%b, required v=0 r=1 s=0 c=0 o=0",
               out_valid, in_ready, out_sum, out_count, out_ovf);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    put(8'd6, 0); put(8'd12, 0); put(8'd225, 1);
    @(negedge clk);
    e = sb.pop_front();
    act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
    checks++;
    if (!out_valid || act !== e) begin
      errors++;
      $display("FAIL basic_result got v=%b %h, required v=1 %h", out_valid, act, e);
    end
    checks++;
    if (out_sum !== 16'd243 || out_count !== 4'd3 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_value got %0d/%0d/%b, required 243/3/0", out_sum, out_count, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold_ready got %b, required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_release got v=%b r=%b, required v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    put(8'd225, 1);
    @(negedge clk);
    e = sb.pop_front();
    act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
    checks++;
    if (!out_valid || act !== e || out_sum !== 16'd225 || out_count !== 4'd1) begin
      errors++;
      $display("FAIL single_result got v=%b %h, required v=1 %h", out_valid, act, e);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    put(8'd10, 0); put(8'd20, 1);
    in_valid = 1'b1; in_prod = 8'd99;
    @(negedge clk);
    e = sb.pop_front();
    act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
    checks++;
    if (!out_valid || act !== e) begin
      errors++;
      $display("FAIL bp_result got v=%b %h, required v=1 %h", out_valid, act, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || act !== e) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got r=%b v=%b %h, required r=0 v=1 %h", i, in_ready, out_valid, act, e);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_sum} !== {1'b0, 1'b1, e.s16}) begin
      errors++;
      $display("FAIL bp_release got v=%b r=%b s=%0d, required v=0 r=1 s=%0d", out_valid, in_ready, out_sum, e.s16);
    end
    put(8'd99, 0); put(8'd1, 1);
    @(negedge clk);
    e = sb.pop_front();
    act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
    checks++;
    if (!out_valid || act !== e || out_sum !== 16'd100 || out_count !== 4'd2) begin
      errors++;
      $display("FAIL bp_next_frame got v=%b %h, required v=1 %h", out_valid, act, e);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    put(8'd225, 0); put(8'd225, 0); put(8'd100, 1);
    @(negedge clk);
    e = sb.pop_front();
    act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
    checks++;
    if (!out_valid9 || act !== e || out_sum9 !== 9'd38 || out_ovf9 !== 1'b1 || out_sum !== 16'd550) begin
      errors++;
      $display("FAIL ovf_result got v=%b %h, required v=1 %h", out_valid9, act, e);
    end
    @(negedge clk);
    put(8'd1, 1);
    @(negedge clk);
    e = sb.pop_front();
    act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
    checks++;
    if (!out_valid9 || act !== e || out_ovf9 !== 1'b0 || out_sum9 !== 9'd1) begin
      errors++;
      $display("FAIL ovf_cleared got v=%b %h, required v=1 %h", out_valid9, act, e);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 20; i++) put(8'd1, i == 20);
    @(negedge clk);
    e = sb.pop_front();
    act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
    checks++;
    if (!out_valid || act !== e || out_sum !== 16'd20 || out_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_result got v=%b %h, required v=1 %h", out_valid, act, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    put(8'd5, 0); put(8'd7, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_valid9, in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL abort_idle cycle %0d got v=%b v9=%b r=%b, required 0 0 1", i, out_valid, out_valid9, in_ready);
      end
    end
    put(8'd9, 1);
    @(negedge clk);
    e = sb.pop_front();
    act = {out_sum, out_sum9, out_count, out_ovf, out_ovf9};
    checks++;
    if (!out_valid || act !== e || out_sum !== 16'd9 || out_count !== 4'd1) begin
      errors++;
      $display("FAIL abort_next_frame got v=%b %h, required v=1 %h", out_valid, act, e);
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_leftover got queue=%0d v=%b, required queue=0 v=0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
